// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared types and constants for the systolic tile sequencer and its neighbours.
package systolic_tile_sequencer_pkg;

   localparam int SYS_ARRAY_SIZE = 4;
   localparam int DATA_W         = 16;

   typedef logic [DATA_W-1:0] data_t;

   // Cycles from the last operand beat on the array inputs to result row 0 on c.
   localparam int SEQ_DRAIN_DLY = 2*SYS_ARRAY_SIZE + 2;

   typedef enum logic [2:0] {
      IDLE,
      FEED,
      FLUSH,
      DRAIN,
      OUT
   } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter. zero_o flags that an enabled decrement takes the
// count to zero on the coming edge, so the caller can change state in step.
module seq_down_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // Load wins over decrement; the count never drops below zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                     cnt_q <= '0;
      else if (load_i)                 cnt_q <= load_val_i;
      else if (en_i && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
   end

   assign zero_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Sequences one NxN output tile on systolic_array_wrap: streams K operand beats
// from the tile buffers, waits out the array drain, then emits N result rows.
// Optional build macro: SEQ_PERF_CNT_EN adds busy-cycle and tile-count counters.
module systolic_tile_sequencer
   import systolic_tile_sequencer_pkg::*;
#(
   parameter int MAX_K     = 256,
   parameter int ADDR_W    = $clog2(MAX_K),
   parameter int DRAIN_DLY = SEQ_DRAIN_DLY
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   start_i,
   input  logic [ADDR_W:0]                        k_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   err_o,
   output logic                                   buf_rd_en_o,
   output logic [ADDR_W-1:0]                      buf_rd_addr_o,
   input  data_t [SYS_ARRAY_SIZE-1:0]             a_buf_i,
   input  data_t [SYS_ARRAY_SIZE-1:0]             b_buf_i,
   output logic                                   sa_en_o,
   output logic                                   sa_last_o,
   output data_t [SYS_ARRAY_SIZE-1:0]             sa_a_o,
   output data_t [SYS_ARRAY_SIZE-1:0]             sa_b_o,
   input  data_t [SYS_ARRAY_SIZE-1:0]             sa_c_i,
   output logic                                   res_valid_o,
   output logic [$clog2(SYS_ARRAY_SIZE)-1:0]      res_row_o,
   output data_t [SYS_ARRAY_SIZE-1:0]             res_data_o
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                            perf_busy_cyc_o,
   output logic [15:0]                            perf_tiles_o
`endif
);

   localparam int N      = SYS_ARRAY_SIZE;
   localparam int ROW_W  = $clog2(N);
   localparam int KW     = ADDR_W + 1;
   localparam int DCNT_W = $clog2(DRAIN_DLY) + 1;

   localparam logic [KW-1:0]     KMAX    = KW'(MAX_K);
   localparam logic [ROW_W:0]    ROW_END = (ROW_W+1)'(N);
   localparam logic [DCNT_W-1:0] DRAIN_LD = DCNT_W'(DRAIN_DLY - 1);

   seq_state_e        state_q, state_d;
   logic              accept, reject;
   logic              beat_last, drain_last;
   logic [ADDR_W-1:0] addr_q;
   logic [ROW_W:0]    row_q;
   logic              sa_en_q, sa_last_q;

   // Beat count: loaded with K on accept, hits zero on the issue of address K-1.
   seq_down_counter #(.W(KW)) u_beat_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept),
      .load_val_i (k_i),
      .en_i       (state_q == FEED),
      .zero_o     (beat_last)
   );

   // Drain wait: loaded during FLUSH, OUT is entered as the count reaches zero.
   seq_down_counter #(.W(DCNT_W)) u_drain_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (state_q == FLUSH),
      .load_val_i (DRAIN_LD),
      .en_i       (state_q == DRAIN),
      .zero_o     (drain_last)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic and start accept/reject decode.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (k_i != '0 && k_i <= KMAX) begin
                  accept  = 1'b1;
                  state_d = FEED;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         FEED:    if (beat_last) state_d = FLUSH;
         FLUSH:   state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = OUT;
         // Row counter runs one past N-1 so done lands after the last row is shown.
         OUT:     if (row_q == ROW_END) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address generation, beat strobes, result capture and status pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q      <= '0;
         row_q       <= '0;
         sa_en_q     <= 1'b0;
         sa_last_q   <= 1'b0;
         res_valid_o <= 1'b0;
         res_row_o   <= '0;
         res_data_o  <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         sa_en_q   <= (state_q == FEED);
         sa_last_q <= (state_q == FEED) && beat_last;
         err_o     <= reject;
         done_o    <= (state_q == OUT) && (row_q == ROW_END);

         if (accept)               addr_q <= '0;
         else if (state_q == FEED) addr_q <= addr_q + 1'b1;

         if (state_q == OUT) row_q <= row_q + 1'b1;
         else                row_q <= '0;

         if (state_q == OUT && row_q != ROW_END) begin
            res_valid_o <= 1'b1;
            res_row_o   <= row_q[ROW_W-1:0];
            res_data_o  <= sa_c_i;
         end else begin
            res_valid_o <= 1'b0;
            res_row_o   <= '0;
            res_data_o  <= '0;
         end
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign buf_rd_en_o   = (state_q == FEED);
   assign buf_rd_addr_o = (state_q == FEED) ? addr_q : '0;
   assign sa_en_o       = sa_en_q;
   assign sa_last_o     = sa_last_q;
   // Buffer data arrives one cycle after issue, aligned with the registered strobe.
   assign sa_a_o        = sa_en_q ? a_buf_i : '0;
   assign sa_b_o        = sa_en_q ? b_buf_i : '0;

`ifdef SEQ_PERF_CNT_EN
   // Busy cycles saturate; tile count wraps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_busy_cyc_o <= '0;
         perf_tiles_o    <= '0;
      end else begin
         if (busy_o && perf_busy_cyc_o != '1) perf_busy_cyc_o <= perf_busy_cyc_o + 1'b1;
         if (done_o)                          perf_tiles_o    <= perf_tiles_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer with a tile-buffer model and
// a cycle-indexed result stream on c.
module tb_systolic_tile_sequencer;
   import systolic_tile_sequencer_pkg::*;

   localparam int N      = 4;
   localparam int D      = 10;
   localparam int MAX_K  = 256;
   localparam int ADDR_W = 8;

   typedef data_t [N-1:0] row_t;
   typedef struct { int cyc; row_t a; row_t b; logic last; } beat_t;
   typedef struct { int cyc; int row; row_t data; } res_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   k = '0;
   logic              busy, done, err, rd_en, sa_en, sa_last, res_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        res_row;
   row_t              a_buf = '0, b_buf = '0;
   row_t              sa_a, sa_b, sa_c, res_data;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0]       perf_busy;
   logic [15:0]       perf_tiles;
`endif

   int checks = 0, failures = 0;
   int cyc = 0;

   beat_t beats[$];
   res_t  ress[$];
   int    dones[$];
   int    errs[$];
   int    n_rd = 0, n_busy = 0, n_gate_bad = 0;
   beat_t mb;
   res_t  mr;

   systolic_tile_sequencer dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .k_i           (k),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .buf_rd_en_o   (rd_en),
      .buf_rd_addr_o (rd_addr),
      .a_buf_i       (a_buf),
      .b_buf_i       (b_buf),
      .sa_en_o       (sa_en),
      .sa_last_o     (sa_last),
      .sa_a_o        (sa_a),
      .sa_b_o        (sa_b),
      .sa_c_i        (sa_c),
      .res_valid_o   (res_valid),
      .res_row_o     (res_row),
      .res_data_o    (res_data)
`ifdef SEQ_PERF_CNT_EN
      ,
      .perf_busy_cyc_o (perf_busy),
      .perf_tiles_o    (perf_tiles)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic row_t exp_a(input int beat);
      row_t r;
      for (int j = 0; j < N; j++) r[j] = data_t'(beat + 1 + j*256);
      return r;
   endfunction

   function automatic row_t exp_b(input int beat);
      row_t r;
      for (int j = 0; j < N; j++) r[j] = data_t'(beat + 1 + 16384 + j*16);
      return r;
   endfunction

   function automatic row_t exp_c(input int c);
      row_t r;
      for (int j = 0; j < N; j++) r[j] = data_t'(c*8 + j + 3);
      return r;
   endfunction

   // Tile buffer: one-cycle read latency; row content encodes the address.
   always @(posedge clk) if (rd_en) begin
      a_buf <= exp_a(int'(rd_addr));
      b_buf <= exp_b(int'(rd_addr));
   end

   // Array output: value depends only on the current cycle number.
   always_comb sa_c = exp_c(cyc);

   // Observation log sampled on the falling edge.
   always @(negedge clk) if (rst_n) begin
      if (sa_en) begin
         mb.cyc = cyc; mb.a = sa_a; mb.b = sa_b; mb.last = sa_last;
         beats.push_back(mb);
      end else if (sa_a != '0 || sa_b != '0 || sa_last) begin
         n_gate_bad = n_gate_bad + 1;
      end
      if (res_valid) begin
         mr.cyc = cyc; mr.row = int'(res_row); mr.data = res_data;
         ress.push_back(mr);
      end
      if (done)  dones.push_back(cyc);
      if (err)   errs.push_back(cyc);
      if (rd_en) n_rd = n_rd + 1;
      if (busy)  n_busy = n_busy + 1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      beats.delete(); ress.delete(); dones.delete(); errs.delete();
      n_rd = 0; n_busy = 0; n_gate_bad = 0;
   endtask

   task automatic pulse_start(input int kk);
      start = 1'b1;
      k = (ADDR_W+1)'(kk);
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_dones(input int target, input int budget, output bit ok);
      int n = 0;
      while (dones.size() < target && n < budget) begin
         step(1);
         n++;
      end
      ok = (dones.size() >= target);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(3);
      checks++;
      if ({busy, done, err, rd_en, sa_en, sa_last, res_valid} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=0", {busy, done, err, rd_en, sa_en, sa_last, res_valid});
      end
      checks++;
      if (rd_addr !== '0 || res_row !== '0) begin
         failures++;
         $display("FAIL reset_addr_row got addr=%0d row=%0d want 0", rd_addr, res_row);
      end
      checks++;
      if (sa_a !== '0 || sa_b !== '0 || res_data !== '0) begin
         failures++;
         $display("FAIL reset_data got a=%h b=%h res=%h want 0", sa_a, sa_b, res_data);
      end
      rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_reset_mid_feed();
      int n = 0;
      int s;
      bit ok;
      clear_log();
      pulse_start(8);
      while (beats.size() < 3 && n < 20) begin
         step(1);
         n++;
      end
      checks++;
      if (beats.size() != 3) begin
         failures++;
         $display("FAIL midrst_beats got=%0d want=3", beats.size());
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, rd_en, sa_en, sa_last, res_valid} !== 7'b0 || sa_a !== '0 || res_data !== '0) begin
         failures++;
         $display("FAIL midrst_outputs got ctrl=%b a=%h res=%h want 0",
                  {busy, done, err, rd_en, sa_en, sa_last, res_valid}, sa_a, res_data);
      end
      step(2);
      rst_n = 1'b1;
      clear_log();
      step(30);
      checks++;
      if (dones.size() != 0 || ress.size() != 0 || beats.size() != 0) begin
         failures++;
         $display("FAIL midrst_residue got done=%0d res=%0d beats=%0d want 0", dones.size(), ress.size(), beats.size());
      end
      clear_log();
      s = cyc;
      pulse_start(2);
      wait_dones(1, 60, ok);
      checks++;
      if (!ok || dones[0] != s + 1 + 2 + D + N + 1) begin
         failures++;
         $display("FAIL midrst_k2_done got ok=%0d cyc=%0d want cyc=%0d", ok, ok ? dones[0] - s : -1, 2 + D + N + 2);
      end
      checks++;
      if (beats.size() != 2 || ress.size() != N) begin
         failures++;
         $display("FAIL midrst_k2_counts got beats=%0d rows=%0d want 2,%0d", beats.size(), ress.size(), N);
      end
      step(2);
   endtask

   task automatic test_single_tile(input int kk);
      int s, l;
      bit ok;
      clear_log();
      s = cyc;
      l = s + 1 + kk;
      pulse_start(kk);
      wait_dones(1, kk + D + N + 20, ok);
      step(2);
      checks++;
      if (!ok || dones.size() != 1) begin
         failures++;
         $display("FAIL k%0d_done_count got=%0d want=1", kk, dones.size());
      end
      checks++;
      if (beats.size() != kk) begin
         failures++;
         $display("FAIL k%0d_beats got=%0d want=%0d", kk, beats.size(), kk);
      end
      for (int j = 0; j < beats.size(); j++) begin
         checks++;
         if (beats[j].cyc != s + 2 + j || beats[j].a !== exp_a(j) || beats[j].b !== exp_b(j)
             || beats[j].last !== (j == kk - 1)) begin
            failures++;
            $display("FAIL k%0d_beat%0d got cyc=+%0d a=%h b=%h last=%b want cyc=+%0d a=%h b=%h last=%b",
                     kk, j, beats[j].cyc - s, beats[j].a, beats[j].b, beats[j].last,
                     2 + j, exp_a(j), exp_b(j), (j == kk - 1));
         end
      end
      checks++;
      if (ress.size() != N) begin
         failures++;
         $display("FAIL k%0d_rows got=%0d want=%0d", kk, ress.size(), N);
      end
      for (int r = 0; r < ress.size(); r++) begin
         checks++;
         if (ress[r].row != r || ress[r].cyc != l + D + 1 + r || ress[r].data !== exp_c(l + D + r)) begin
            failures++;
            $display("FAIL k%0d_row%0d got row=%0d cyc=+%0d data=%h want row=%0d cyc=+%0d data=%h",
                     kk, r, ress[r].row, ress[r].cyc - s, ress[r].data, r, l + D + 1 + r - s, exp_c(l + D + r));
         end
      end
      if (dones.size() > 0) begin
         checks++;
         if (dones[0] != l + D + N + 1) begin
            failures++;
            $display("FAIL k%0d_done_latency got=%0d want=%0d", kk, dones[0] - l, D + N + 1);
         end
      end
      checks++;
      if (n_busy != kk + D + N + 1 || n_rd != kk) begin
         failures++;
         $display("FAIL k%0d_busy_rd got busy=%0d rd=%0d want busy=%0d rd=%0d", kk, n_busy, n_rd, kk + D + N + 1, kk);
      end
      checks++;
      if (n_gate_bad != 0 || errs.size() != 0) begin
         failures++;
         $display("FAIL k%0d_gating got gate_bad=%0d errs=%0d want 0", kk, n_gate_bad, errs.size());
      end
   endtask

   task automatic test_err();
      int s1, s2;
      clear_log();
      s1 = cyc;
      pulse_start(0);
      step(2);
      s2 = cyc;
      pulse_start(MAX_K + 1);
      step(3);
      checks++;
      if (errs.size() != 2) begin
         failures++;
         $display("FAIL err_count got=%0d want=2", errs.size());
      end else begin
         checks++;
         if (errs[0] != s1 + 1 || errs[1] != s2 + 1) begin
            failures++;
            $display("FAIL err_timing got=+%0d,+%0d want=+1,+1", errs[0] - s1, errs[1] - s2);
         end
      end
      checks++;
      if (n_busy != 0 || n_rd != 0 || beats.size() != 0) begin
         failures++;
         $display("FAIL err_side_effects got busy=%0d rd=%0d beats=%0d want 0", n_busy, n_rd, beats.size());
      end
   endtask

   task automatic test_back_to_back();
      int s;
      bit ok;
      clear_log();
      s = cyc;
      pulse_start(4);
      step(1);
      start = 1'b1;
      k = 9'd2;
      step(1);
      start = 1'b0;
      step(17);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_cycle got done=%b busy=%b want done=1 busy=0", done, busy);
      end
      pulse_start(3);
      wait_dones(2, 80, ok);
      step(2);
      checks++;
      if (!ok || dones[0] != s + 20 || dones[1] != s + 39) begin
         failures++;
         $display("FAIL b2b_dones got n=%0d want +20,+39", dones.size());
      end
      checks++;
      if (beats.size() != 7 || ress.size() != 2*N || errs.size() != 0) begin
         failures++;
         $display("FAIL b2b_counts got beats=%0d rows=%0d errs=%0d want 7,%0d,0", beats.size(), ress.size(), errs.size(), 2*N);
      end
      if (beats.size() == 7) begin
         checks++;
         if (beats[4].cyc != s + 22 || beats[4].a !== exp_a(0) || beats[6].last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_tile got cyc=+%0d a=%h last=%b want cyc=+22 a=%h last=1",
                     beats[4].cyc - s, beats[4].a, beats[6].last, exp_a(0));
         end
      end
      checks++;
      if (n_busy != 37) begin
         failures++;
         $display("FAIL b2b_busy got=%0d want=37", n_busy);
      end
   endtask

`ifdef SEQ_PERF_CNT_EN
   task automatic test_perf();
      bit ok;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      clear_log();
      pulse_start(4);
      wait_dones(1, 60, ok);
      pulse_start(4);
      wait_dones(2, 60, ok);
      step(3);
      checks++;
      if (perf_tiles !== 16'd2) begin
         failures++;
         $display("FAIL perf_tiles got=%0d want=2", perf_tiles);
      end
      checks++;
      if (perf_busy !== 32'd38) begin
         failures++;
         $display("FAIL perf_busy got=%0d want=38", perf_busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_feed();
      test_single_tile(4);
      test_single_tile(1);
      test_single_tile(MAX_K);
      test_err();
      test_back_to_back();
`ifdef SEQ_PERF_CNT_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
